chimera_cluster_pwr_seq: RTL and testbench

Shared power-state sequencer for the external accelerator clusters. It turns per-cluster enable requests from the top-level register file into ordered clock-gate, reset and AXI-isolation transitions, serving one cluster at a time. Pending clusters are picked round-robin. It sits between the top-level register region (one clock gate per cluster) and the per-cluster clock gates, reset lines and AXI isolation cells on the narrow and wide master ports.

---
 rtl/chimera_cluster_pwr_seq.sv | 170 +++++++++++++++++
 tb/tb_chimera_cluster_pwr_seq.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chimera_cluster_pwr_seq.sv
// Shared power sequencer for the external accelerator clusters.
// Serves one cluster at a time, picked round-robin from the clusters whose requested
// state differs from their current state. Power-up order is clock, reset release, then
// de-isolation. Power-down order is isolation, a wait for the drain ack, reset, then clock stop.
module chimera_cluster_pwr_seq #(
    parameter int unsigned NumClusters     = 5,
    parameter int unsigned ClkSettleCycles = 4,
    parameter int unsigned RstRelCycles    = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumClusters-1:0] cluster_en_i,
    input  logic [NumClusters-1:0] isolated_i,
    output logic [NumClusters-1:0] clk_en_o,
    output logic [NumClusters-1:0] rst_o,
    output logic [NumClusters-1:0] isolate_o,
    output logic [NumClusters-1:0] ready_o,
    output logic                   busy_o
);

    localparam int unsigned MaxCycles = (ClkSettleCycles > RstRelCycles) ?
                                        ClkSettleCycles : RstRelCycles;
    localparam int unsigned CntW = $clog2(MaxCycles) + 1;
    localparam int unsigned SelW = (NumClusters > 1) ? $clog2(NumClusters) : 1;

    localparam logic [CntW-1:0] ClkLoad  = CntW'(ClkSettleCycles - 1);
    localparam logic [CntW-1:0] RstLoad  = CntW'(RstRelCycles - 1);
    localparam logic [SelW-1:0] LastInit = SelW'(NumClusters - 1);

    typedef enum logic [2:0] {
        StIdle,
        StUpClk,
        StUpRst,
        StUpDone,
        StDnIso,
        StDnRst,
        StDnClk
    } state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [SelW-1:0]        sel_q, sel_d;
    logic [SelW-1:0]        last_q, last_d;
    logic [NumClusters-1:0] clk_en_q, clk_en_d;
    logic [NumClusters-1:0] rst_q, rst_d;
    logic [NumClusters-1:0] iso_q, iso_d;
    logic [NumClusters-1:0] ready_q, ready_d;
    logic                   busy_q, busy_d;

    logic [NumClusters-1:0] pending;
    logic [SelW-1:0]        idx;
    logic [SelW-1:0]        grant;
    logic                   grant_vld;

    // Round-robin pick: first pending cluster strictly after the last one granted.
    always_comb begin
        pending   = cluster_en_i ^ ready_q;
        idx       = '0;
        grant     = '0;
        grant_vld = 1'b0;
        for (int unsigned k = 1; k <= NumClusters; k++) begin
            idx = SelW'((32'(last_q) + k) % NumClusters);
            if (!grant_vld && pending[idx]) begin
                grant_vld = 1'b1;
                grant     = idx;
            end
        end
    end

    // Next state and next per-cluster outputs; only the selected cluster's bits move.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        last_d   = last_q;
        clk_en_d = clk_en_q;
        rst_d    = rst_q;
        iso_d    = iso_q;
        ready_d  = ready_q;
        unique case (state_q)
            StIdle: begin
                if (grant_vld) begin
                    sel_d  = grant;
                    last_d = grant;
                    if (ready_q[grant]) begin
                        state_d        = StDnIso;
                        iso_d[grant]   = 1'b1;
                        ready_d[grant] = 1'b0;
                    end else begin
                        state_d         = StUpClk;
                        clk_en_d[grant] = 1'b1;
                        rst_d[grant]    = 1'b1;
                        cnt_d           = ClkLoad;
                    end
                end
            end
            StUpClk: begin
                if (cnt_q == '0) begin
                    state_d      = StUpRst;
                    rst_d[sel_q] = 1'b0;
                    iso_d[sel_q] = 1'b1;
                    cnt_d        = RstLoad;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StUpRst: begin
                if (cnt_q == '0) begin
                    state_d        = StUpDone;
                    iso_d[sel_q]   = 1'b0;
                    ready_d[sel_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StUpDone: state_d = StIdle;
            StDnIso: begin
                // No timeout: the cluster must drain before its reset can be asserted.
                if (isolated_i[sel_q]) begin
                    state_d      = StDnRst;
                    rst_d[sel_q] = 1'b1;
                    cnt_d        = ClkLoad;
                end
            end
            StDnRst: begin
                if (cnt_q == '0) begin
                    state_d         = StDnClk;
                    clk_en_d[sel_q] = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDnClk: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    // State and registered outputs, asynchronously forced to the safe off state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            sel_q    <= '0;
            last_q   <= LastInit;
            clk_en_q <= '0;
            rst_q    <= '1;
            iso_q    <= '1;
            ready_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            clk_en_q <= clk_en_d;
            rst_q    <= rst_d;
            iso_q    <= iso_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign clk_en_o  = clk_en_q;
    assign rst_o     = rst_q;
    assign isolate_o = iso_q;
    assign ready_o   = ready_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_chimera_cluster_pwr_seq.sv
// Bench for chimera_cluster_pwr_seq: directed scenarios plus a random soak, all checked
// every cycle against a timeline model built from the sequencing rules.
module tb_chimera_cluster_pwr_seq;

    localparam int N = 5;
    localparam int C = 4;
    localparam int R = 8;

    localparam logic [4*N:0] RstVec = {{N{1'b0}}, {N{1'b1}}, {N{1'b1}}, {N{1'b0}}, 1'b0};

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] cluster_en;
    logic [N-1:0] isolated;
    logic [N-1:0] clk_en;
    logic [N-1:0] c_rst;
    logic [N-1:0] isolate;
    logic [N-1:0] ready;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: current expected outputs plus the timeline of the sequence in flight.
    logic [N-1:0] m_clk, m_rst, m_iso, m_ready;
    logic         m_busy;
    int           m_last, m_g, m_n, m_ack_n;
    bit           m_act, m_up, m_acked;

    logic [4*N:0] dut_vec;
    logic [4*N:0] m_vec;
    assign dut_vec = {clk_en, c_rst, isolate, ready, busy};
    assign m_vec   = {m_clk, m_rst, m_iso, m_ready, m_busy};

    always #5 clk = ~clk;

    chimera_cluster_pwr_seq #(
        .NumClusters    (N),
        .ClkSettleCycles(C),
        .RstRelCycles   (R)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cluster_en_i(cluster_en),
        .isolated_i  (isolated),
        .clk_en_o    (clk_en),
        .rst_o       (c_rst),
        .isolate_o   (isolate),
        .ready_o     (ready),
        .busy_o      (busy)
    );

    task automatic model_reset();
        m_clk   = '0;
        m_rst   = '1;
        m_iso   = '1;
        m_ready = '0;
        m_busy  = 1'b0;
        m_last  = N - 1;
        m_act   = 1'b0;
    endtask

    // One clock edge: n counts edges since the grant; the edge that grants is n = 1.
    task automatic model_edge();
        logic [N-1:0] pend;
        bit found;
        if (rst) begin
            model_reset();
            return;
        end
        if (!m_act) begin
            pend  = cluster_en ^ m_ready;
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                int id;
                id = (m_last + k) % N;
                if (!found && pend[id]) begin
                    found = 1'b1;
                    m_g   = id;
                end
            end
            if (found) begin
                m_last  = m_g;
                m_act   = 1'b1;
                m_up    = !m_ready[m_g];
                m_n     = 1;
                m_acked = 1'b0;
                m_busy  = 1'b1;
                if (m_up) begin
                    m_clk[m_g] = 1'b1;
                end else begin
                    m_iso[m_g]   = 1'b1;
                    m_ready[m_g] = 1'b0;
                end
            end
        end else begin
            m_n++;
            if (m_up) begin
                if (m_n == 1 + C) m_rst[m_g] = 1'b0;
                if (m_n == 1 + C + R) begin
                    m_iso[m_g]   = 1'b0;
                    m_ready[m_g] = 1'b1;
                end
                if (m_n == 2 + C + R) begin
                    m_busy = 1'b0;
                    m_act  = 1'b0;
                end
            end else if (!m_acked) begin
                if (isolated[m_g]) begin
                    m_acked    = 1'b1;
                    m_ack_n    = m_n;
                    m_rst[m_g] = 1'b1;
                end
            end else begin
                if (m_n == m_ack_n + C) m_clk[m_g] = 1'b0;
                if (m_n == m_ack_n + C + 1) begin
                    m_busy = 1'b0;
                    m_act  = 1'b0;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Leaves the bench in cycle 0 with reset released and all requests off.
    task automatic do_reset();
        rst        = 1'b1;
        cluster_en = '0;
        isolated   = '0;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        cluster_en = '0;
        isolated   = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (dut_vec !== RstVec) begin
            n_bad++;
            $display("FAIL reset_values got %h want %h", dut_vec, RstVec);
        end
        cluster_en = '1;
        isolated   = '1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (dut_vec !== RstVec) begin
            n_bad++;
            $display("FAIL reset_holds got %h want %h", dut_vec, RstVec);
        end
    endtask

    task automatic test_power_up();
        int  rise_clk = -1, fall_rst = -1, fall_iso = -1, rise_rdy = -1, fall_busy = -1;
        bit  others_ok = 1'b1;
        do_reset();
        cluster_en = 5'b00001;
        for (int n = 1; n <= 18; n++) begin
            cycle();
            n_cmp++;
            if (dut_vec !== m_vec) begin
                n_bad++;
                $display("FAIL power_up n=%0d got %h want %h", n, dut_vec, m_vec);
            end
            if (clk_en[0] && rise_clk < 0) rise_clk = n;
            if (!c_rst[0] && fall_rst < 0) fall_rst = n;
            if (!isolate[0] && fall_iso < 0) fall_iso = n;
            if (ready[0] && rise_rdy < 0) rise_rdy = n;
            if (rise_clk > 0 && !busy && fall_busy < 0) fall_busy = n;
            if ({clk_en[4:1], c_rst[4:1], isolate[4:1], ready[4:1]} !== 16'h0ff0) others_ok = 0;
        end
        n_cmp += 6;
        if (rise_clk != 1) begin
            n_bad++; $display("FAIL up_clk_en_rise got %0d want 1", rise_clk);
        end
        if (fall_rst != 1 + C) begin
            n_bad++; $display("FAIL up_rst_fall got %0d want %0d", fall_rst, 1 + C);
        end
        if (fall_iso != 1 + C + R) begin
            n_bad++; $display("FAIL up_iso_fall got %0d want %0d", fall_iso, 1 + C + R);
        end
        if (rise_rdy != 1 + C + R) begin
            n_bad++; $display("FAIL up_ready_rise got %0d want %0d", rise_rdy, 1 + C + R);
        end
        if (fall_busy != 2 + C + R) begin
            n_bad++; $display("FAIL up_busy_fall got %0d want %0d", fall_busy, 2 + C + R);
        end
        if (!others_ok) begin
            n_bad++; $display("FAIL up_others_disturbed got 1 want 0");
        end
    endtask

    task automatic test_all_on();
        int rise[N];
        for (int i = 0; i < N; i++) rise[i] = -1;
        do_reset();
        cluster_en = '1;
        for (int n = 1; n <= 80; n++) begin
            cycle();
            n_cmp++;
            if (dut_vec !== m_vec) begin
                n_bad++;
                $display("FAIL all_on n=%0d got %h want %h", n, dut_vec, m_vec);
            end
            for (int i = 0; i < N; i++) if (ready[i] && rise[i] < 0) rise[i] = n;
        end
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (rise[i] != 13 + 14 * i) begin
                n_bad++;
                $display("FAIL all_on_order cl=%0d got %0d want %0d", i, rise[i], 13 + 14 * i);
            end
        end
    endtask

    task automatic test_power_down();
        int  rise_iso = -1, rise_rst = -1, fall_clk = -1, fall_busy = -1;
        do_reset();
        cluster_en = 5'b00100;
        for (int n = 1; n <= 15; n++) begin
            cycle();
            n_cmp++;
            if (dut_vec !== m_vec) begin
                n_bad++;
                $display("FAIL down_setup n=%0d got %h want %h", n, dut_vec, m_vec);
            end
        end
        cluster_en = '0;
        for (int n = 1; n <= 32; n++) begin
            cycle();
            n_cmp++;
            if (dut_vec !== m_vec) begin
                n_bad++;
                $display("FAIL power_down n=%0d got %h want %h", n, dut_vec, m_vec);
            end
            if (isolate[2] && rise_iso < 0) rise_iso = n;
            if (c_rst[2] && rise_rst < 0) rise_rst = n;
            if (!clk_en[2] && fall_clk < 0) fall_clk = n;
            if (!busy && fall_busy < 0) fall_busy = n;
            if (n == 21) isolated[2] = 1'b1;
        end
        isolated = '0;
        n_cmp += 4;
        if (rise_iso != 1) begin
            n_bad++; $display("FAIL dn_iso_rise got %0d want 1", rise_iso);
        end
        if (rise_rst != 22) begin
            n_bad++; $display("FAIL dn_rst_rise got %0d want 22", rise_rst);
        end
        if (fall_clk != 22 + C) begin
            n_bad++; $display("FAIL dn_clk_fall got %0d want %0d", fall_clk, 22 + C);
        end
        if (fall_busy != 23 + C) begin
            n_bad++; $display("FAIL dn_busy_fall got %0d want %0d", fall_busy, 23 + C);
        end
    endtask

    task automatic test_toggle_ignored();
        int rise1 = -1, rise3 = -1;
        bit went_down = 1'b0;
        do_reset();
        cluster_en = 5'b00010;
        for (int n = 1; n <= 45; n++) begin
            cycle();
            n_cmp++;
            if (dut_vec !== m_vec) begin
                n_bad++;
                $display("FAIL toggle n=%0d got %h want %h", n, dut_vec, m_vec);
            end
            if (ready[1] && rise1 < 0) rise1 = n;
            if (ready[3] && rise3 < 0) rise3 = n;
            if ((rise1 > 0 && !ready[1]) || !clk_en[1]) went_down = 1'b1;
            if (n == 3) cluster_en[1] = 1'b0;
            if (n == 5) cluster_en = 5'b01010;
        end
        n_cmp += 3;
        if (rise1 != 13) begin
            n_bad++; $display("FAIL toggle_cl1_ready got %0d want 13", rise1);
        end
        if (rise3 != 27) begin
            n_bad++; $display("FAIL toggle_cl3_ready got %0d want 27", rise3);
        end
        if (went_down) begin
            n_bad++; $display("FAIL toggle_cl1_went_down got 1 want 0");
        end
    endtask

    task automatic test_reset_mid();
        int rise_rdy = -1;
        do_reset();
        cluster_en = 5'b00001;
        for (int n = 1; n <= 8; n++) begin
            cycle();
            n_cmp++;
            if (dut_vec !== m_vec) begin
                n_bad++;
                $display("FAIL reset_mid_pre n=%0d got %h want %h", n, dut_vec, m_vec);
            end
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (dut_vec !== RstVec) begin
            n_bad++;
            $display("FAIL reset_mid_async got %h want %h", dut_vec, RstVec);
        end
        model_reset();
        cycle();
        cycle();
        rst = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            cycle();
            n_cmp++;
            if (dut_vec !== m_vec) begin
                n_bad++;
                $display("FAIL reset_mid_post n=%0d got %h want %h", n, dut_vec, m_vec);
            end
            if (ready[0] && rise_rdy < 0) rise_rdy = n;
        end
        n_cmp++;
        if (rise_rdy != 13) begin
            n_bad++; $display("FAIL reset_mid_restart got %0d want 13", rise_rdy);
        end
    endtask

    task automatic test_rr_wrap();
        int rise1 = -1, rise4 = -1;
        do_reset();
        cluster_en = 5'b01000;
        for (int n = 1; n <= 15; n++) cycle();
        cluster_en = 5'b11010;
        for (int n = 1; n <= 35; n++) begin
            cycle();
            n_cmp++;
            if (dut_vec !== m_vec) begin
                n_bad++;
                $display("FAIL rr_wrap n=%0d got %h want %h", n, dut_vec, m_vec);
            end
            if (ready[1] && rise1 < 0) rise1 = n;
            if (ready[4] && rise4 < 0) rise4 = n;
        end
        n_cmp += 2;
        if (rise4 != 13) begin
            n_bad++; $display("FAIL rr_first_cl4 got %0d want 13", rise4);
        end
        if (rise1 != 27) begin
            n_bad++; $display("FAIL rr_second_cl1 got %0d want 27", rise1);
        end
    endtask

    task automatic test_random();
        int b;
        do_reset();
        for (int n = 1; n <= 3000; n++) begin
            cycle();
            n_cmp++;
            if (dut_vec !== m_vec) begin
                n_bad++;
                $display("FAIL random n=%0d got %h want %h", n, dut_vec, m_vec);
            end
            if ($urandom_range(0, 9) == 0) begin
                b = $urandom_range(0, N - 1);
                cluster_en[b] = ~cluster_en[b];
            end
            isolated = N'($urandom & $urandom);
            rst      = ($urandom_range(0, 599) == 0);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_all_on();
        test_power_down();
        test_toggle_ignored();
        test_reset_mid();
        test_rr_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
